// File: rtl/cache_pkg.sv
// cache_pkg: shared types, geometry helpers and small utilities for dm_cache.
package cache_pkg;

  // Tag storage is sized for the smallest legal cache (2 sets), so a line
  // struct can hold the tag of any legal geometry zero-extended.
  localparam int         MAX_TAG_W = 29;
  localparam logic [3:0] ALL_LANES = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WTHRU,
    RESP
  } cache_state_e;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          data;
  } line_t;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets);
    return 30 - $clog2(sets);
  endfunction

  // Counter increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/global_pkg.sv
// Global: project-wide shared types.
package Global;

  typedef logic [31:0] size_t;

endpackage

// File: rtl/dm_cache_array.sv
// dm_cache_array: valid/tag/data storage with a combinational lookup port and
// a single byte-enabled write port. Fill mode also writes the tag and sets valid.
module dm_cache_array
  import cache_pkg::*;
#(
  parameter  int SETS  = 16,
  localparam int IDX_W = idx_w(SETS),
  localparam int TAG_W = tag_w(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_lk_idx,
  input  logic [TAG_W-1:0] i_lk_tag,
  output logic             o_hit,
  output logic [31:0]      o_data,
  input  logic             i_we,
  input  logic             i_fill,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [3:0]       i_wr_be,
  input  logic [31:0]      i_wr_data
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS];
  line_t            w_line;

  // Assemble the addressed line for the lookup port.
  always_comb begin
    w_line.valid = r_valid[i_lk_idx];
    w_line.tag   = MAX_TAG_W'(r_tag[i_lk_idx]);
    w_line.data  = r_data[i_lk_idx];
  end

  assign o_hit  = w_line.valid && (w_line.tag == MAX_TAG_W'(i_lk_tag));
  assign o_data = w_line.data;

  // Valid bits are the only storage that must come up clean after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_we && i_fill) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays; data is written lane by lane so write hits can merge.
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_fill) begin
        r_tag[i_wr_idx] <= i_wr_tag;
      end
      for (int b = 0; b < 4; b++) begin
        if (i_wr_be[b]) begin
          r_data[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-through, no-write-allocate cache, one word per
// line, presenting the memory request/response protocol on both sides.
module dm_cache
  import cache_pkg::*;
#(
  parameter  int SETS  = 16,
  localparam int IDX_W = idx_w(SETS),
  localparam int TAG_W = tag_w(SETS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          read,
  input  logic          write,
  input  logic [3:0]    byte_enable,
  input  Global::size_t address,
  input  Global::size_t wdata,
  output logic          resp,
  output logic [31:0]   rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [3:0]    mem_byte_enable,
  output Global::size_t mem_address,
  output Global::size_t mem_wdata,
  input  logic          mem_resp,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
);

  cache_state_e  r_state;
  logic          r_resp;
  logic [31:0]   r_rdata;
  logic          r_mem_read;
  logic          r_mem_write;
  logic [3:0]    r_mem_be;
  Global::size_t r_mem_address;
  Global::size_t r_mem_wdata;
  logic [31:0]   r_hit_count;
  logic [31:0]   r_miss_count;

  cache_state_e  w_state_nxt;
  logic          w_resp_nxt;
  logic [31:0]   w_rdata_nxt;
  logic          w_mem_read_nxt;
  logic          w_mem_write_nxt;
  logic [3:0]    w_mem_be_nxt;
  Global::size_t w_mem_address_nxt;
  Global::size_t w_mem_wdata_nxt;
  logic [31:0]   w_hit_count_nxt;
  logic [31:0]   w_miss_count_nxt;

  Global::size_t w_lk_addr;
  logic          w_hit;
  logic [31:0]   w_hit_data;
  logic          w_arr_we;
  logic          w_arr_fill;
  logic [3:0]    w_arr_be;
  logic [31:0]   w_arr_data;
  logic          w_unused;

  // While a write-through is in flight the lookup must follow the latched
  // address, since the CPU inputs are not sampled outside IDLE.
  assign w_lk_addr = (r_state == WTHRU) ? r_mem_address : address;
  assign w_unused  = ^w_lk_addr[1:0];

  dm_cache_array #(
    .SETS(SETS)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_lk_idx (w_lk_addr[IDX_W+1:2]),
    .i_lk_tag (w_lk_addr[31:IDX_W+2]),
    .o_hit    (w_hit),
    .o_data   (w_hit_data),
    .i_we     (w_arr_we),
    .i_fill   (w_arr_fill),
    .i_wr_idx (r_mem_address[IDX_W+1:2]),
    .i_wr_tag (r_mem_address[31:IDX_W+2]),
    .i_wr_be  (w_arr_be),
    .i_wr_data(w_arr_data)
  );

  // Next-state, next-output and array-write decisions for every FSM state.
  always_comb begin
    w_state_nxt       = r_state;
    w_resp_nxt        = 1'b0;
    w_rdata_nxt       = r_rdata;
    w_mem_read_nxt    = r_mem_read;
    w_mem_write_nxt   = r_mem_write;
    w_mem_be_nxt      = r_mem_be;
    w_mem_address_nxt = r_mem_address;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_hit_count_nxt   = r_hit_count;
    w_miss_count_nxt  = r_miss_count;
    w_arr_we          = 1'b0;
    w_arr_fill        = 1'b0;
    w_arr_be          = r_mem_be;
    w_arr_data        = r_mem_wdata;

    case (r_state)
      IDLE: begin
        if (write) begin
          w_mem_write_nxt   = 1'b1;
          w_mem_address_nxt = {address[31:2], 2'b00};
          w_mem_wdata_nxt   = wdata;
          w_mem_be_nxt      = byte_enable;
          w_state_nxt       = WTHRU;
        end else if (read) begin
          if (w_hit) begin
            w_rdata_nxt     = w_hit_data;
            w_resp_nxt      = 1'b1;
            w_hit_count_nxt = sat_inc(r_hit_count);
            w_state_nxt     = RESP;
          end else begin
            w_mem_read_nxt    = 1'b1;
            w_mem_address_nxt = {address[31:2], 2'b00};
            w_mem_be_nxt      = ALL_LANES;
            w_miss_count_nxt  = sat_inc(r_miss_count);
            w_state_nxt       = FILL;
          end
        end
      end
      FILL: begin
        if (mem_resp) begin
          w_arr_we       = 1'b1;
          w_arr_fill     = 1'b1;
          w_arr_be       = ALL_LANES;
          w_arr_data     = mem_rdata;
          w_rdata_nxt    = mem_rdata;
          w_resp_nxt     = 1'b1;
          w_mem_read_nxt = 1'b0;
          w_state_nxt    = RESP;
        end
      end
      WTHRU: begin
        if (mem_resp) begin
          w_arr_we        = w_hit;
          w_resp_nxt      = 1'b1;
          w_mem_write_nxt = 1'b0;
          w_state_nxt     = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered-output update; reset abandons any open transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_resp        <= 1'b0;
      r_rdata       <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_be      <= '0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_resp        <= w_resp_nxt;
      r_rdata       <= w_rdata_nxt;
      r_mem_read    <= w_mem_read_nxt;
      r_mem_write   <= w_mem_write_nxt;
      r_mem_be      <= w_mem_be_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_hit_count   <= w_hit_count_nxt;
      r_miss_count  <= w_miss_count_nxt;
    end
  end

  assign resp            = r_resp;
  assign rdata           = r_rdata;
  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_byte_enable = r_mem_be;
  assign mem_address     = r_mem_address;
  assign mem_wdata       = r_mem_wdata;
  assign hit_count       = r_hit_count;
  assign miss_count      = r_miss_count;

endmodule

// File: doc/dm_cache.md
Name: dm_cache

Overview:
- Direct-mapped, write-through, no-write-allocate cache with one 32-bit word per line.
- Sits between `cpu` and `memory`. On its CPU side it exposes the same request/response port set that `memory` presents to `cpu`, so it drops into `top` with no changes to `cpu`.
- Hits complete without a memory access. Misses and all writes go to `memory` using the same hold-until-resp protocol.

Parameters:
- SETS, 16, number of lines; power of two, minimum 2.
- IDX_W, $clog2(SETS), index width; derived, not overridden.
- TAG_W, 30-IDX_W, tag width; derived.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- read  input  1  CPU read request; held until resp.
- write  input  1  CPU write request; held until resp.
- byte_enable  input  4  CPU write byte lanes; ignored on reads.
- address  input  Global::size_t  CPU byte address; bits [1:0] ignored.
- wdata  input  Global::size_t  CPU write data.
- resp  output  1  one-cycle completion pulse to CPU.
- rdata  output  32  read data; valid when resp=1.
- mem_read  output  1  memory read request; held until mem_resp.
- mem_write  output  1  memory write request; held until mem_resp.
- mem_byte_enable  output  4  memory write lanes; 4'hF on reads.
- mem_address  output  Global::size_t  word-aligned memory address (bits [1:0]=0).
- mem_wdata  output  Global::size_t  memory write data.
- mem_resp  input  1  memory completion pulse.
- mem_rdata  input  32  memory read data; valid with mem_resp.
- hit_count  output  32  saturating count of read hits.
- miss_count  output  32  saturating count of read misses.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs, both counters and all valid bits clear to 0; FSM goes to IDLE.
  - Tag and data arrays need no reset.
  - Reset mid-transaction abandons the request. mem_read and mem_write drop to 0 immediately.
- Address split: index = address[IDX_W+1:2], tag = address[31:IDX_W+2].
- FSM states: IDLE, FILL, WTHRU, RESP.
- IDLE:
  - write=1: latch address, wdata and byte_enable; drive mem_write=1 registered; go to WTHRU. Write takes priority if read and write are both 1 (illegal CPU behaviour, but defined).
  - read=1 and hit (valid & tag match): rdata <= line data, resp <= 1, hit_count++; go to RESP. Latency is one cycle from request to resp.
  - read=1 and miss: mem_read <= 1, mem_address <= {address[31:2],2'b00}; miss_count++; go to FILL.
- FILL: hold the memory request. On mem_resp:
  - write tag and data, set valid;
  - rdata <= mem_rdata, resp <= 1, mem_read <= 0;
  - go to RESP.
- WTHRU: hold mem_write, mem_byte_enable and mem_wdata. On mem_resp:
  - if the latched address hits, merge wdata into the cached word per byte_enable;
  - a miss leaves the array untouched (no allocate);
  - resp <= 1, mem_write <= 0; go to RESP.
- RESP:
  - resp=1 for exactly this cycle; next state IDLE, resp returns to 0.
  - The request still visible this cycle is ignored, which prevents re-execution.
  - Maximum throughput is one hit every 2 cycles.
- rdata holds its last value outside resp.
- mem_read and mem_write are never both 1.
- CPU inputs are sampled only in IDLE. Changes in other states are ignored.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- mem_resp outside FILL or WTHRU is ignored.

Decomposition:
- Package cache_pkg holds:
  - the FSM enum `cache_state_e`;
  - localparam functions for IDX_W and TAG_W;
  - the `line_t` struct {valid, tag, data}.
- Global::size_t stays in Global.
- Sub-module dm_cache_array holds the valid/tag/data storage:
  - combinational lookup port giving hit and data;
  - one write port with per-byte enables and a fill mode;
  - async clear of valid.

Test Plan:
- Cold read 0x0000_0040: mem_read rises 1 cycle after request; mem_resp with 0xDEADBEEF → resp 1 cycle later with rdata=0xDEADBEEF, miss_count=1.
- Repeat read 0x40 → resp on next cycle, rdata=0xDEADBEEF, no mem_read, hit_count=1.
- Write 0x40, wdata=0x11223344, byte_enable=4'b0011 → mem_write with the same lanes; after mem_resp, a read of 0x40 hits with 0xDEAD3344.
- Conflict: read 0x0000_0440 (same index as 0x40 at SETS=16, different tag) → miss and refill. A subsequent read of 0x40 misses again.
- Write to uncached 0x80, then read 0x80 → read misses, confirming no allocate; miss_count increments.
- Assert rst_n=0 while in FILL → mem_read=0 in the same cycle, resp=0. After release, read 0x40 misses, confirming valid bits were cleared.
